fetch_pair_aligner: RTL and testbench

//  Consumer end of the dual-lane data fetch path. Accepts up to two fetched words per

---
 rtl/fetch_pair_aligner_pkg.sv | 22 ++
 rtl/fetch_pair_ram.sv | 32 +++
 rtl/fetch_pair_aligner.sv | 99 +++++++++
 tb/tb_fetch_pair_aligner.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pair_aligner_pkg.sv
// Shared definitions for the dual-lane fetch path: default word width, take encodings
// and zero-flag polarity, plus the take-clamping helper used by the aligner.
package fetch_pair_aligner_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [1:0] TAKE_NONE = 2'd0;
  localparam logic [1:0] TAKE_ONE  = 2'd1;
  localparam logic [1:0] TAKE_TWO  = 2'd2;

  // Level of in_zer* that marks a word as zero (discarded)
  localparam logic ZERO_FLAG = 1'b1;

  // Illegal take=3 behaves as two; never consume more than what is buffered
  function automatic logic [1:0] clamp_take(input logic [1:0] take, input logic [1:0] avail);
    logic [1:0] t;
    t = (take == 2'd3) ? TAKE_TWO : take;
    if (t == TAKE_NONE) return TAKE_NONE;
    return (t > avail) ? avail : t;
  endfunction

endpackage

// File: rtl/fetch_pair_ram.sv
// DEPTH x WIDTH register storage with two write ports and two asynchronous read ports.
// Storage is never reset; the aligner's pointers decide which entries are meaningful.
module fetch_pair_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             we0,
  input  logic [AW-1:0]    waddr0,
  input  logic [WIDTH-1:0] wdata0,
  input  logic             we1,
  input  logic [AW-1:0]    waddr1,
  input  logic [WIDTH-1:0] wdata1,
  input  logic [AW-1:0]    raddr0,
  output logic [WIDTH-1:0] rdata0,
  input  logic [AW-1:0]    raddr1,
  output logic [WIDTH-1:0] rdata1
);

  logic [WIDTH-1:0] mem [DEPTH];

  // The aligner never drives both ports at the same address in one cycle
  always_ff @(posedge clk) begin
    if (we0) mem[waddr0] <= wdata0;
    if (we1) mem[waddr1] <= wdata1;
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/fetch_pair_aligner.sv
// Compacts up to two non-zero fetched words per cycle into a circular buffer and
// presents the two oldest words, in program order, to the dual-issue decoder.
module fetch_pair_aligner
  import fetch_pair_aligner_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = 8,
  parameter int PTRW  = 3
) (
  input  logic             clk,
  input  logic             preset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data0,
  input  logic [WIDTH-1:0] in_data1,
  input  logic             in_zer0,
  input  logic             in_zer1,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic             out_valid0,
  output logic             out_valid1,
  input  logic [1:0]       out_take,
  output logic [PTRW:0]    level,
  output logic             take_err
);

  localparam int CW = PTRW + 1;

  logic [PTRW-1:0] wr_ptr;
  logic [PTRW-1:0] rd_ptr;
  logic [CW-1:0]   count;
  logic            err_q;

  logic            keep0;
  logic            keep1;
  logic            accept;
  logic [1:0]      nwr;
  logic [1:0]      avail;
  logic [1:0]      eff_take;
  logic            err_now;
  logic            we0;
  logic            we1;
  logic [WIDTH-1:0] wdata0;

  // Conservative: a take in the same cycle does not free space for the incoming pair
  assign in_ready = (count <= CW'(DEPTH - 2));
  assign accept   = in_valid && in_ready;
  assign keep0    = (in_zer0 != ZERO_FLAG);
  assign keep1    = (in_zer1 != ZERO_FLAG);
  assign nwr      = accept ? ({1'b0, keep0} + {1'b0, keep1}) : 2'd0;

  // Port 0 always writes the oldest survivor at wr_ptr; port 1 only when both survive
  assign we0    = accept && (keep0 || keep1);
  assign we1    = accept && keep0 && keep1;
  assign wdata0 = keep0 ? in_data0 : in_data1;

  assign avail    = (count >= CW'(2)) ? TAKE_TWO : ((count == '0) ? TAKE_NONE : TAKE_ONE);
  assign eff_take = clamp_take(out_take, avail);
  assign err_now  = (out_take == 2'd3) || (CW'(out_take) > count);

  fetch_pair_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PTRW)
  ) u_ram (
    .clk    (clk),
    .we0    (we0),
    .waddr0 (wr_ptr),
    .wdata0 (wdata0),
    .we1    (we1),
    .waddr1 (wr_ptr + PTRW'(1)),
    .wdata1 (in_data1),
    .raddr0 (rd_ptr),
    .rdata0 (out_data0),
    .raddr1 (rd_ptr + PTRW'(1)),
    .rdata1 (out_data1)
  );

  // Pointers wrap naturally at PTRW bits; take_err is sticky until preset
  always_ff @(posedge clk) begin
    if (preset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err_q  <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + PTRW'(nwr);
      rd_ptr <= rd_ptr + PTRW'(eff_take);
      count  <= count + CW'(nwr) - CW'(eff_take);
      if (err_now) err_q <= 1'b1;
    end
  end

  assign out_valid0 = (count != '0);
  assign out_valid1 = (count >= CW'(2));
  assign level      = count;
  assign take_err   = err_q;

endmodule

// File: tb/tb_fetch_pair_aligner.sv
// Self-checking bench for fetch_pair_aligner: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based reference model.
module tb_fetch_pair_aligner;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int PTRW  = 3;

  logic             clk = 1'b0;
  logic             preset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data0;
  logic [WIDTH-1:0] in_data1;
  logic             in_zer0;
  logic             in_zer1;
  logic [WIDTH-1:0] out_data0;
  logic [WIDTH-1:0] out_data1;
  logic             out_valid0;
  logic             out_valid1;
  logic [1:0]       out_take;
  logic [PTRW:0]    level;
  logic             take_err;

  int checks = 0;
  int errors = 0;

  // Reference model: buffered words oldest-first, plus the sticky error flag
  logic [WIDTH-1:0] mq[$];
  logic             merr;

  typedef struct {
    logic        v;
    logic        z0;
    logic        z1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  take;
    int          lvl;
    logic        rdy;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  vec_t vecs[9];

  fetch_pair_aligner #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTRW(PTRW)) dut (
    .clk        (clk),
    .preset     (preset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data0   (in_data0),
    .in_data1   (in_data1),
    .in_zer0    (in_zer0),
    .in_zer1    (in_zer1),
    .out_data0  (out_data0),
    .out_data1  (out_data1),
    .out_valid0 (out_valid0),
    .out_valid1 (out_valid1),
    .out_take   (out_take),
    .level      (level),
    .take_err   (take_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    int n;
    n = mq.size();
    check({tag, " level"}, 64'(level), 64'(n));
    check({tag, " in_ready"}, 64'(in_ready), 64'((DEPTH - n) >= 2));
    check({tag, " out_valid0"}, 64'(out_valid0), 64'(n >= 1));
    check({tag, " out_valid1"}, 64'(out_valid1), 64'(n >= 2));
    check({tag, " take_err"}, 64'(take_err), 64'(merr));
    if (n >= 1) check({tag, " out_data0"}, 64'(out_data0), 64'(mq[0]));
    if (n >= 2) check({tag, " out_data1"}, 64'(out_data1), 64'(mq[1]));
  endtask

  // Drive one cycle, advance the model at the edge, then check just after it
  task automatic applyStimulus(input logic v, input logic z0, input logic z1,
                               input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                               input logic [1:0] take, input string tag);
    int n;
    int t;
    bit acc;
    @(negedge clk);
    preset   = 1'b0;
    in_valid = v;
    in_zer0  = z0;
    in_zer1  = z1;
    in_data0 = d0;
    in_data1 = d1;
    out_take = take;
    @(posedge clk);
    n   = mq.size();
    acc = v && ((DEPTH - n) >= 2);
    if (take == 2'd3 || int'(take) > n) merr = 1'b1;
    t = (take == 2'd3) ? 2 : int'(take);
    if (t > n) t = n;
    repeat (t) void'(mq.pop_front());
    if (acc) begin
      if (!z0) mq.push_back(d0);
      if (!z1) mq.push_back(d1);
    end
    #1;
    checkOutput(tag);
  endtask

  task automatic doReset();
    @(negedge clk);
    preset   = 1'b1;
    in_valid = 1'b0;
    in_zer0  = 1'b0;
    in_zer1  = 1'b0;
    in_data0 = '0;
    in_data1 = '0;
    out_take = 2'd0;
    @(posedge clk);
    mq.delete();
    merr = 1'b0;
    #1;
    check("reset level", 64'(level), 64'd0);
    check("reset out_valid0", 64'(out_valid0), 64'd0);
    check("reset out_valid1", 64'(out_valid1), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset take_err", 64'(take_err), 64'd0);
  endtask

  initial begin
    logic [WIDTH-1:0] w;
    logic [1:0] tk;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'd1,  32'd2,  2'd0, 2, 1'b1, 32'd1, 32'd2};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 32'd3,  32'd4,  2'd2, 1, 1'b1, 32'd4, 32'd0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 32'd5,  32'd6,  2'd0, 2, 1'b1, 32'd4, 32'd5};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 32'd99, 32'd99, 2'd0, 2, 1'b1, 32'd4, 32'd5};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 32'd7,  32'd8,  2'd0, 4, 1'b1, 32'd4, 32'd5};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 32'd9,  32'd10, 2'd0, 6, 1'b1, 32'd4, 32'd5};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 32'd11, 32'd12, 2'd0, 7, 1'b0, 32'd4, 32'd5};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 32'd13, 32'd14, 2'd0, 7, 1'b0, 32'd4, 32'd5};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 32'd0,  32'd0,  2'd2, 5, 1'b1, 32'd7, 32'd8};

    doReset();

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].v, vecs[i].z0, vecs[i].z1, vecs[i].d0, vecs[i].d1,
                    vecs[i].take, $sformatf("vec%0d", i));
      check($sformatf("vec%0d tbl level", i), 64'(level), 64'(vecs[i].lvl));
      check($sformatf("vec%0d tbl in_ready", i), 64'(in_ready), 64'(vecs[i].rdy));
      check($sformatf("vec%0d tbl take_err", i), 64'(take_err), 64'd0);
      check($sformatf("vec%0d tbl out_data0", i), 64'(out_data0), 64'(vecs[i].e0));
      if (vecs[i].lvl >= 2)
        check($sformatf("vec%0d tbl out_data1", i), 64'(out_data1), 64'(vecs[i].e1));
    end

    // Drain to a single word, then write a pair while over-taking
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 2'd2, "drain1");
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 2'd2, "drain2");
    check("drain level", 64'(level), 64'd1);
    check("drain out_data0", 64'(out_data0), 64'd11);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd15, 32'd16, 2'd2, "overtake");
    check("overtake level", 64'(level), 64'd2);
    check("overtake take_err", 64'(take_err), 64'd1);
    check("overtake out_data0", 64'(out_data0), 64'd15);
    check("overtake out_data1", 64'(out_data1), 64'd16);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 2'd0, "sticky");
    check("sticky take_err", 64'(take_err), 64'd1);

    // 40-word stream, taking as much as is legal each cycle
    doReset();
    for (int i = 0; i < 20; i++) begin
      tk = (mq.size() >= 2) ? 2'd2 : 2'(mq.size());
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h100 + 32'(2 * i), 32'h101 + 32'(2 * i), tk,
                    $sformatf("stream%0d", i));
    end
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 2'd2, "stream_drain");
    check("stream take_err", 64'(take_err), 64'd0);
    check("stream level", 64'(level), 64'd0);

    // Randomized traffic with legal takes
    for (int i = 0; i < 300; i++) begin
      w  = $urandom;
      tk = 2'($urandom_range(0, 2));
      if (int'(tk) > mq.size()) tk = 2'(mq.size());
      applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 3) == 0), w, ~w ^ 32'($urandom), tk,
                    $sformatf("rand%0d", i));
    end
    check("rand take_err", 64'(take_err), 64'd0);

    // Illegal take encoding sets the sticky error
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 2'd3, "take3");
    check("take3 take_err", 64'(take_err), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
